bcd_mes_loader: RTL and testbench

- Inverse path of the month up/down counter: assembles a two-digit BCD month entered one digit at a time (keypad or switches plus strobe).
- Validates the range 01..12 and hands the counter a zero-based load index (0..11) over a req/ack handshake.
- Sits between the user-input front end and the month counter in the date-setting section.
- Also echoes the digits being typed so the display shows the entry in progress.

---
 rtl/bcd_mes_pkg.sv | 32 +++
 rtl/bcd_mes_loader_edge_tick.sv | 24 ++
 rtl/bcd_mes_loader.sv | 161 ++++++++++++++++
 tb/tb_bcd_mes_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_mes_pkg.sv
// Shared definitions for the date-setting loaders: FSM states, field-select codes, month range.
package bcd_mes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GOT_D1 = 3'd1,
      ST_CHECK  = 3'd2,
      ST_LOAD   = 3'd3,
      ST_ERR    = 3'd4
   } state_t;

   // en_count codes driven by the setting FSM
   localparam logic [3:0] FIELD_SEG  = 4'd1;
   localparam logic [3:0] FIELD_MIN  = 4'd2;
   localparam logic [3:0] FIELD_HORA = 4'd3;
   localparam logic [3:0] FIELD_DIA  = 4'd4;
   localparam logic [3:0] FIELD_MES  = 4'd5;
   localparam logic [3:0] FIELD_ANO  = 4'd6;

   localparam int unsigned MES_MIN = 1;
   localparam int unsigned MES_MAX = 12;

   typedef struct packed {
      logic [3:0] d1;
      logic [3:0] d0;
   } entry_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bcd_mes_loader_edge_tick.sv
// Registered rising-edge detector; suppresses a tick for a level already high at reset release.
module edge_tick (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic tick_c
);

   logic level_q;
   logic armed;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q <= 1'b0;
         armed   <= 1'b0;
      end else begin
         level_q <= level;
         armed   <= 1'b1;
      end
   end

   assign tick_c = level & ~level_q & armed;

endmodule

// File: rtl/bcd_mes_loader.sv
// Two-digit BCD month entry: captures digits, validates 01..12, hands month-1 to the counter via req/ack.
module bcd_mes_loader
   import bcd_mes_pkg::*;
#(
   parameter logic [3:0]  SEL_MES  = FIELD_MES,
   parameter int unsigned TIMEOUT  = 50000000,
   parameter int unsigned ERR_HOLD = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] en_count,
   input  logic       digit_strobe,
   input  logic [3:0] digit_in,
   input  logic       clear,
   input  logic       load_ack,
   output logic [3:0] q_load,
   output logic       load_req,
   output logic [3:0] digit1_echo,
   output logic [3:0] digit0_echo,
   output logic       busy,
   output logic       error
);

   localparam int unsigned TW = $clog2(max_u(TIMEOUT, ERR_HOLD) + 1);

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n, timer_inc;
   entry_t        entry, entry_n;
   logic [3:0]    q_load_n, digit1_n, digit0_n;
   logic          load_req_n, busy_n, error_n;
   logic          tick, sel, valid;
   logic [4:0]    value;

   edge_tick u_edge_tick (
      .clk    (clk),
      .reset  (reset),
      .level  (digit_strobe),
      .tick_c (tick)
   );

   assign sel       = (en_count == SEL_MES);
   assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);

   // d1*10 + d0 via shifts, kept to 5 bits
   assign value = (5'(entry.d1) << 3) + (5'(entry.d1) << 1) + 5'(entry.d0);
   assign valid = (entry.d1 <= 4'd1) && (entry.d0 <= 4'd9) &&
                  (value >= 5'(MES_MIN)) && (value <= 5'(MES_MAX));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         timer       <= '0;
         entry       <= '0;
         q_load      <= 4'd0;
         load_req    <= 1'b0;
         digit1_echo <= 4'd0;
         digit0_echo <= 4'd0;
         busy        <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         entry       <= entry_n;
         q_load      <= q_load_n;
         load_req    <= load_req_n;
         digit1_echo <= digit1_n;
         digit0_echo <= digit0_n;
         busy        <= busy_n;
         error       <= error_n;
      end
   end

   always_comb begin
      state_n    = state;
      timer_n    = timer;
      entry_n    = entry;
      q_load_n   = q_load;
      load_req_n = load_req;
      digit1_n   = digit1_echo;
      digit0_n   = digit0_echo;
      error_n    = error;

      if (clear) begin
         state_n    = ST_IDLE;
         timer_n    = '0;
         load_req_n = 1'b0;
         error_n    = 1'b0;
         digit1_n   = 4'd0;
         digit0_n   = 4'd0;
      end else if (!sel && (state == ST_GOT_D1 || state == ST_CHECK)) begin
         state_n  = ST_IDLE;
         timer_n  = '0;
         digit1_n = 4'd0;
         digit0_n = 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tick && sel) begin
                  entry_n.d1 = digit_in;
                  digit1_n   = digit_in;
                  digit0_n   = 4'd0;
                  timer_n    = '0;
                  error_n    = 1'b0;
                  state_n    = ST_GOT_D1;
               end
            end
            ST_GOT_D1: begin
               // a tick on the timeout cycle still counts as the second digit
               if (tick) begin
                  entry_n.d0 = digit_in;
                  digit0_n   = digit_in;
                  state_n    = ST_CHECK;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  timer_n  = '0;
                  error_n  = 1'b1;
                  digit1_n = 4'd0;
                  digit0_n = 4'd0;
                  state_n  = ST_ERR;
               end else begin
                  timer_n = timer_inc;
               end
            end
            ST_CHECK: begin
               if (valid) begin
                  q_load_n   = 4'(value - 5'd1);
                  load_req_n = 1'b1;
                  state_n    = ST_LOAD;
               end else begin
                  timer_n  = '0;
                  error_n  = 1'b1;
                  digit1_n = 4'd0;
                  digit0_n = 4'd0;
                  state_n  = ST_ERR;
               end
            end
            ST_LOAD: begin
               if (load_ack) begin
                  load_req_n = 1'b0;
                  state_n    = ST_IDLE;
               end
            end
            ST_ERR: begin
               if (timer == TW'(ERR_HOLD - 1)) begin
                  timer_n = '0;
                  error_n = 1'b0;
                  state_n = ST_IDLE;
               end else begin
                  timer_n = timer_inc;
               end
            end
            default: begin
               state_n = ST_IDLE;
               timer_n = '0;
            end
         endcase
      end

      busy_n = (state_n != ST_IDLE);
   end

endmodule

// File: tb/tb_bcd_mes_loader.sv
// Randomized bench for bcd_mes_loader against a cycle-offset timeline model of each entry.
module tb_bcd_mes_loader;

   localparam int unsigned TO   = 20;
   localparam int unsigned HOLD = 8;
   localparam logic [3:0]  SEL  = 4'd5;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] en_count;
   logic       digit_strobe;
   logic [3:0] digit_in;
   logic       clear;
   logic       load_ack;
   logic [3:0] q_load;
   logic       load_req;
   logic [3:0] digit1_echo;
   logic [3:0] digit0_echo;
   logic       busy;
   logic       error;

   int errors = 0;
   int checks = 0;

   bcd_mes_loader #(.SEL_MES(SEL), .TIMEOUT(TO), .ERR_HOLD(HOLD)) dut (
      .clk          (clk),
      .reset        (reset),
      .en_count     (en_count),
      .digit_strobe (digit_strobe),
      .digit_in     (digit_in),
      .clear        (clear),
      .load_ack     (load_ack),
      .q_load       (q_load),
      .load_req     (load_req),
      .digit1_echo  (digit1_echo),
      .digit0_echo  (digit0_echo),
      .busy         (busy),
      .error        (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_all(input string tag, input int e_busy, input int e_req, input int e_err,
                            input int e_d1, input int e_d0);
      check({tag, "_busy"}, int'(busy), e_busy);
      check({tag, "_req"}, int'(load_req), e_req);
      check({tag, "_err"}, int'(error), e_err);
      check({tag, "_d1"}, int'(digit1_echo), e_d1);
      check({tag, "_d0"}, int'(digit0_echo), e_d0);
   endtask

   // Full two-digit entry; expectations come from the month rules and fixed latencies
   task automatic do_entry(input int d1, input int d0, input int hold1, input int gap,
                           input int hold0, input int ack_dly);
      int  month;
      bit  ok;
      int  last;
      month = d1 * 10 + d0;
      ok    = (d1 <= 1) && (d0 <= 9) && (month >= 1) && (month <= 12);
      en_count = SEL;
      check("pre_busy", int'(busy), 0);
      digit_in     = 4'(d1);
      digit_strobe = 1'b1;
      step();
      check_all("d1_cap", 1, 0, 0, d1, 0);
      for (int i = 1; i < hold1; i++) begin
         step();
         check("d1_hold_d0", int'(digit0_echo), 0);
      end
      digit_strobe = 1'b0;
      for (int i = 0; i < gap; i++) step();
      check("gap_busy", int'(busy), 1);
      digit_in     = 4'(d0);
      digit_strobe = 1'b1;
      last = ok ? 3 + ack_dly : 2 + int'(HOLD);
      for (int c = 1; c <= last; c++) begin
         step();
         if (c == 1)
            check_all("chk", 1, 0, 0, d1, d0);
         else if (ok && c <= 2 + ack_dly) begin
            check_all("load", 1, 1, 0, d1, d0);
            check("q_load", int'(q_load), month - 1);
         end else if (ok)
            check_all("done", 0, 0, 0, d1, d0);
         else if (c <= 1 + int'(HOLD))
            check_all("err", 1, 0, 1, 0, 0);
         else
            check_all("err_end", 0, 0, 0, 0, 0);
         if (c >= hold0) digit_strobe = 1'b0;
         if (ok && c == 2 + ack_dly) load_ack = 1'b1;
      end
      load_ack     = 1'b0;
      digit_strobe = 1'b0;
      step();
      check("post_idle", int'(busy), 0);
   endtask

   initial begin
      reset        = 1'b0;
      en_count     = SEL;
      digit_strobe = 1'b0;
      digit_in     = 4'd0;
      clear        = 1'b0;
      load_ack     = 1'b0;
      #3;
      check_all("rst", 0, 0, 0, 0, 0);
      check("rst_q", int'(q_load), 0);
      step();
      step();
      reset = 1'b1;
      step();

      // directed cases
      do_entry(1, 2, 1, 2, 1, 3);
      do_entry(0, 7, 10, 1, 10, 2);
      do_entry(1, 3, 1, 1, 1, 0);
      do_entry(0, 0, 2, 1, 1, 0);
      do_entry(10, 1, 1, 1, 1, 0);

      // timeout: one digit and nothing else
      digit_in = 4'd1;
      digit_strobe = 1'b1;
      step();
      digit_strobe = 1'b0;
      for (int c = 1; c <= int'(TO + HOLD); c++) begin
         step();
         check("to_err", int'(error), (c >= int'(TO) && c < int'(TO + HOLD)) ? 1 : 0);
         check("to_busy", int'(busy), (c < int'(TO + HOLD)) ? 1 : 0);
         check("to_d1", int'(digit1_echo), (c < int'(TO)) ? 1 : 0);
      end

      // clear abort
      digit_in = 4'd0;
      digit_strobe = 1'b1;
      step();
      digit_strobe = 1'b0;
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_all("clr", 0, 0, 0, 0, 0);
      step();
      check("clr_stay", int'(busy), 0);

      // field deselect abort
      digit_strobe = 1'b1;
      step();
      check("sel_cap", int'(busy), 1);
      digit_strobe = 1'b0;
      en_count = 4'd3;
      step();
      check_all("desel", 0, 0, 0, 0, 0);
      digit_strobe = 1'b1;
      step();
      check("nosel_tick", int'(busy), 0);
      digit_strobe = 1'b0;
      en_count = SEL;
      step();
      do_entry(0, 9, 1, 1, 1, 1);

      // async reset while in LOAD, with strobe high across release
      digit_in = 4'd1;
      digit_strobe = 1'b1;
      step();
      digit_strobe = 1'b0;
      step();
      digit_strobe = 1'b1;
      step();
      step();
      check("pre_rst_req", int'(load_req), 1);
      #1;
      reset = 1'b0;
      #1;
      check_all("arst", 0, 0, 0, 0, 0);
      check("arst_q", int'(q_load), 0);
      step();
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rel_busy", int'(busy), 0);
         check("rel_req", int'(load_req), 0);
      end
      digit_strobe = 1'b0;
      step();

      // randomized entries
      for (int n = 0; n < 30; n++) begin
         int d1, d0;
         d1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1));
         d0 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
         do_entry(d1, d0, int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                  int'($urandom_range(1, 6)), int'($urandom_range(0, 4)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
